// File: rtl/game_state_ctrl_if.sv
// Handshake bundle between the game-flow controller and the rest of the game:
// player/board status levels in, flow state, pacing pulses and life count out.
interface game_state_ctrl_if;
  logic       start;
  logic       crash;
  logic       board_clear;
  logic       pause_sw;
  logic [2:0] state;
  logic       game_tick;
  logic       run_en;
  logic       respawn;
  logic [1:0] lives;
  logic       over;
  logic       win;

  modport master (
    output start, crash, board_clear, pause_sw,
    input  state, game_tick, run_en, respawn, lives, over, win
  );

  modport slave (
    input  start, crash, board_clear, pause_sw,
    output state, game_tick, run_en, respawn, lives, over, win
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Game-flow FSM: READY countdown, play, pause, death pause, win/lose end states,
// plus the free-running game tick prescaler and the gated movement enable.
module game_state_ctrl #(
  parameter int TICK_DIV    = 2500000,
  parameter int READY_TICKS = 80,
  parameter int DEATH_TICKS = 40,
  parameter int LIVES       = 3
) (
  input  logic              clk,
  input  logic              rst,
  game_state_ctrl_if.slave  gs
);
  localparam int PW   = $clog2(TICK_DIV);
  localparam int TMAX = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_READY    = TW'(READY_TICKS);
  localparam logic [TW-1:0] T_DEATH    = TW'(DEATH_TICKS);
  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_DYING = 3'd4,
    S_OVER  = 3'd5,
    S_WIN   = 3'd6
  } state_t;

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic [TW-1:0] timer_reg;
  logic [1:0]    lives_reg;
  logic          over_reg;
  logic          win_reg;
  logic          tick_reg;
  logic          run_en_reg;
  logic          respawn_reg;
  logic          play_next;
  logic          tick_next;

  assign tick_next = (presc_reg == PRESC_MAX);

  // run_en must line up with the tick it gates, so it looks at where the FSM is heading.
  assign play_next = (state_reg == S_PLAY  && !gs.board_clear && !gs.crash && !gs.pause_sw)
                  || (state_reg == S_READY && tick_reg && timer_reg == T_ONE)
                  || (state_reg == S_PAUSE && !gs.pause_sw);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      presc_reg   <= '0;
      timer_reg   <= '0;
      lives_reg   <= LIVES_INIT;
      over_reg    <= 1'b0;
      win_reg     <= 1'b0;
      tick_reg    <= 1'b0;
      run_en_reg  <= 1'b0;
      respawn_reg <= 1'b0;
    end else begin
      presc_reg   <= tick_next ? '0 : presc_reg + PW'(1);
      tick_reg    <= tick_next;
      run_en_reg  <= tick_next && play_next;
      respawn_reg <= 1'b0;

      case (state_reg)
        S_IDLE, S_OVER, S_WIN: begin
          if (gs.start) begin
            state_reg   <= S_READY;
            lives_reg   <= LIVES_INIT;
            timer_reg   <= T_READY;
            over_reg    <= 1'b0;
            win_reg     <= 1'b0;
            respawn_reg <= 1'b1;
          end
        end
        S_READY: begin
          if (tick_reg) begin
            if (timer_reg == T_ONE) state_reg <= S_PLAY;
            timer_reg <= timer_reg - T_ONE;
          end
        end
        S_PLAY: begin
          if (gs.board_clear) begin
            state_reg <= S_WIN;
            win_reg   <= 1'b1;
            over_reg  <= 1'b1;
          end else if (gs.crash) begin
            state_reg <= S_DYING;
            lives_reg <= lives_reg - 2'd1;
            timer_reg <= T_DEATH;
          end else if (gs.pause_sw) begin
            state_reg <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (!gs.pause_sw) state_reg <= S_PLAY;
        end
        S_DYING: begin
          if (tick_reg) begin
            if (timer_reg == T_ONE) begin
              if (lives_reg == 2'd0) begin
                state_reg <= S_OVER;
                over_reg  <= 1'b1;
              end else begin
                state_reg   <= S_READY;
                timer_reg   <= T_READY;
                respawn_reg <= 1'b1;
              end
            end else begin
              timer_reg <= timer_reg - T_ONE;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign gs.state     = state_reg;
  assign gs.game_tick = tick_reg;
  assign gs.run_en    = run_en_reg;
  assign gs.respawn   = respawn_reg;
  assign gs.lives     = lives_reg;
  assign gs.over      = over_reg;
  assign gs.win       = win_reg;
endmodule
